// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller and its datapath: FSM states,
// instruction classes, opcode/funct constants and every datapath select code.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CL_RCALC,
        CL_ICALC,
        CL_LOAD,
        CL_STORE,
        CL_BEQ,
        CL_J,
        CL_JAL,
        CL_JR,
        CL_NOP,
        CL_ILLEGAL
    } iclass_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [2:0] NPC_PLUS4 = 3'd0;
    localparam logic [2:0] NPC_BEQ   = 3'd1;
    localparam logic [2:0] NPC_J     = 3'd2;
    localparam logic [2:0] NPC_JR    = 3'd3;

    localparam logic [1:0] RA_RT = 2'd0;
    localparam logic [1:0] RA_RD = 2'd1;
    localparam logic [1:0] RA_31 = 2'd2;

    localparam logic [2:0] RD_ALU = 3'd0;
    localparam logic [2:0] RD_MEM = 3'd1;
    localparam logic [2:0] RD_PC  = 3'd2;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_OR  = 4'd2;
    localparam logic [3:0] ALU_LUI = 4'd3;

    localparam logic [2:0] B_RT   = 3'd0;
    localparam logic [2:0] B_ZEXT = 3'd1;
    localparam logic [2:0] B_SEXT = 3'd2;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath/memory bundle: datapath status and memory handshakes in,
// selects and write strobes out.
interface mc_ctrl_if;

    logic [31:0] instr;
    logic        zero;
    logic        imem_ready;
    logic        dmem_ready;

    logic        imem_req;
    logic        dmem_req;
    logic        mem_write;
    logic        ir_write;
    logic        pc_write;
    logic [2:0]  next_pc_op;
    logic        reg_write;
    logic [1:0]  reg_addr_op;
    logic [2:0]  reg_data_op;
    logic [3:0]  alu_op;
    logic [2:0]  alu_b_op;
    logic        illegal;

    modport master (
        input  instr, zero, imem_ready, dmem_ready,
        output imem_req, dmem_req, mem_write, ir_write, pc_write, next_pc_op,
               reg_write, reg_addr_op, reg_data_op, alu_op, alu_b_op, illegal
    );

    modport slave (
        output instr, zero, imem_ready, dmem_ready,
        input  imem_req, dmem_req, mem_write, ir_write, pc_write, next_pc_op,
               reg_write, reg_addr_op, reg_data_op, alu_op, alu_b_op, illegal
    );

endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier: IR word -> instruction class plus the
// ALU operation and B-operand select used in EXEC.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output iclass_e     iclass,
    output logic [3:0]  alu_op,
    output logic [2:0]  alu_b_op
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        iclass   = CL_ILLEGAL;
        alu_op   = ALU_ADD;
        alu_b_op = B_RT;
        if (instr == 32'd0) begin
            iclass = CL_NOP;
        end else begin
            case (opcode)
                OP_RTYPE: begin
                    case (funct)
                        FN_ADDU: iclass = CL_RCALC;
                        FN_SUBU: begin
                            iclass = CL_RCALC;
                            alu_op = ALU_SUB;
                        end
                        FN_JR:   iclass = CL_JR;
                        default: iclass = CL_ILLEGAL;
                    endcase
                end
                OP_ORI: begin
                    iclass   = CL_ICALC;
                    alu_op   = ALU_OR;
                    alu_b_op = B_ZEXT;
                end
                OP_LUI: begin
                    iclass   = CL_ICALC;
                    alu_op   = ALU_LUI;
                    alu_b_op = B_ZEXT;
                end
                OP_LW: begin
                    iclass   = CL_LOAD;
                    alu_b_op = B_SEXT;
                end
                OP_SW: begin
                    iclass   = CL_STORE;
                    alu_b_op = B_SEXT;
                end
                OP_BEQ: begin
                    iclass = CL_BEQ;
                    alu_op = ALU_SUB;
                end
                OP_J:    iclass = CL_J;
                OP_JAL:  iclass = CL_JAL;
                default: iclass = CL_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: FETCH/DECODE/EXEC/MEM/WB sequencer driving every
// datapath select and strobe, plus a retired-instruction counter.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    mc_ctrl_if.master        bus,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    iclass_e          iclass;
    logic [3:0]       dec_alu_op;
    logic [2:0]       dec_alu_b_op;

    logic             imem_req, dmem_req, mem_write, ir_write, pc_write;
    logic             reg_write, illegal;
    logic [2:0]       next_pc_op, reg_data_op, alu_b_op;
    logic [1:0]       reg_addr_op;
    logic [3:0]       alu_op;

    mc_decode u_decode (
        .instr    (bus.instr),
        .iclass   (iclass),
        .alu_op   (dec_alu_op),
        .alu_b_op (dec_alu_b_op)
    );

    always_comb begin
        state_d     = state_q;
        retired_d   = retired_q;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        next_pc_op  = NPC_PLUS4;
        reg_write   = 1'b0;
        reg_addr_op = RA_RT;
        reg_data_op = RD_ALU;
        alu_op      = ALU_ADD;
        alu_b_op    = B_RT;
        illegal     = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_pc_op = NPC_PLUS4;
                    state_d    = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_FETCH;
                case (iclass)
                    CL_RCALC, CL_ICALC, CL_LOAD, CL_STORE, CL_BEQ: state_d = ST_EXEC;
                    CL_J: begin
                        pc_write   = 1'b1;
                        next_pc_op = NPC_J;
                    end
                    CL_JAL: begin
                        pc_write    = 1'b1;
                        next_pc_op  = NPC_J;
                        reg_write   = 1'b1;
                        reg_addr_op = RA_31;
                        reg_data_op = RD_PC;
                    end
                    CL_JR: begin
                        pc_write   = 1'b1;
                        next_pc_op = NPC_JR;
                    end
                    CL_ILLEGAL: illegal = 1'b1;
                    default: ;
                endcase
            end
            ST_EXEC: begin
                alu_op   = dec_alu_op;
                alu_b_op = dec_alu_b_op;
                case (iclass)
                    CL_LOAD, CL_STORE: state_d = ST_MEM;
                    CL_RCALC, CL_ICALC: state_d = ST_WB;
                    CL_BEQ: begin
                        pc_write   = bus.zero;
                        next_pc_op = NPC_BEQ;
                        state_d    = ST_FETCH;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                dmem_req  = 1'b1;
                mem_write = (iclass == CL_STORE);
                if (bus.dmem_ready) begin
                    state_d = (iclass == CL_LOAD) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB: begin
                reg_write   = 1'b1;
                reg_addr_op = (iclass == CL_RCALC) ? RA_RD : RA_RT;
                reg_data_op = (iclass == CL_LOAD) ? RD_MEM : RD_ALU;
                state_d     = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase

        // Any return to FETCH from a working state completes an instruction.
        if (state_d == ST_FETCH && state_q != ST_FETCH && state_q != ST_IDLE) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign retired         = retired_q;
    assign bus.imem_req    = imem_req;
    assign bus.dmem_req    = dmem_req;
    assign bus.mem_write   = mem_write;
    assign bus.ir_write    = ir_write;
    assign bus.pc_write    = pc_write;
    assign bus.next_pc_op  = next_pc_op;
    assign bus.reg_write   = reg_write;
    assign bus.reg_addr_op = reg_addr_op;
    assign bus.reg_data_op = reg_data_op;
    assign bus.alu_op      = alu_op;
    assign bus.alu_b_op    = alu_b_op;
    assign bus.illegal     = illegal;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: a per-instruction trace model expands each
// instruction into its expected cycle-by-cycle outputs, replayed and compared each cycle.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] retired;

    mc_ctrl_if bus ();

    mc_ctrl #(.CNT_W(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .retired (retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic [2:0] npc;
        logic       reg_write;
        logic [1:0] ra;
        logic [2:0] rd;
        logic [3:0] alu;
        logic [2:0] alub;
        logic       illegal;
    } outv_t;

    typedef struct {
        logic        rst_n;
        logic [31:0] instr;
        logic        zero;
        logic        irdy;
        logic        drdy;
        outv_t       exp;
        logic [31:0] exp_ret;
    } rec_t;

    typedef enum int {K_R, K_I, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR, K_NOP, K_ILL} kind_e;

    rec_t        q[$];
    logic [31:0] model_ret = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic kind_e kind_of(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] fn;
        op = w[31:26];
        fn = w[5:0];
        if (w == 32'd0) return K_NOP;
        case (op)
            6'h00:   return (fn == 6'h21 || fn == 6'h23) ? K_R : (fn == 6'h08) ? K_JR : K_ILL;
            6'h0D, 6'h0F: return K_I;
            6'h23:   return K_LW;
            6'h2B:   return K_SW;
            6'h04:   return K_BEQ;
            6'h02:   return K_J;
            6'h03:   return K_JAL;
            default: return K_ILL;
        endcase
    endfunction

    // {alu_op, alu_b_op} expected during EXEC
    function automatic logic [6:0] alu_of(input logic [31:0] w);
        logic [5:0] op;
        op = w[31:26];
        case (kind_of(w))
            K_R:         return (w[5:0] == 6'h23) ? {4'd1, 3'd0} : {4'd0, 3'd0};
            K_I:         return (op == 6'h0D) ? {4'd2, 3'd1} : {4'd3, 3'd1};
            K_LW, K_SW:  return {4'd0, 3'd2};
            K_BEQ:       return {4'd1, 3'd0};
            default:     return 7'd0;
        endcase
    endfunction

    function automatic outv_t dut_out();
        outv_t o;
        o.imem_req  = bus.imem_req;
        o.dmem_req  = bus.dmem_req;
        o.mem_write = bus.mem_write;
        o.ir_write  = bus.ir_write;
        o.pc_write  = bus.pc_write;
        o.npc       = bus.next_pc_op;
        o.reg_write = bus.reg_write;
        o.ra        = bus.reg_addr_op;
        o.rd        = bus.reg_data_op;
        o.alu       = bus.alu_op;
        o.alub      = bus.alu_b_op;
        o.illegal   = bus.illegal;
        return o;
    endfunction

    task automatic emit(input logic rst_n, input logic [31:0] w, input logic z, input logic irdy,
                        input logic drdy, input outv_t o, input int cut, inout int n);
        rec_t r;
        r.rst_n   = rst_n;
        r.instr   = w;
        r.zero    = z;
        r.irdy    = irdy;
        r.drdy    = drdy;
        r.exp     = o;
        r.exp_ret = model_ret;
        if (cut < 0 || n < cut) q.push_back(r);
        n++;
    endtask

    // Expand one instruction into its cycles; cut >= 0 keeps only that many and abandons it.
    task automatic add_instr(input logic [31:0] w, input logic z, input int iw, input int dw,
                             input int cut);
        kind_e k;
        outv_t o;
        int    n;
        k = kind_of(w);
        n = 0;
        for (int i = 0; i <= iw; i++) begin
            o = '0;
            o.imem_req = 1'b1;
            if (i == iw) begin
                o.ir_write = 1'b1;
                o.pc_write = 1'b1;
            end
            emit(1'b1, $urandom(), 1'($urandom), (i == iw), 1'($urandom), o, cut, n);
        end
        o = '0;
        case (k)
            K_J:   begin o.pc_write = 1'b1; o.npc = 3'd2; end
            K_JAL: begin o.pc_write = 1'b1; o.npc = 3'd2; o.reg_write = 1'b1; o.ra = 2'd2; o.rd = 3'd2; end
            K_JR:  begin o.pc_write = 1'b1; o.npc = 3'd3; end
            K_ILL: o.illegal = 1'b1;
            default: ;
        endcase
        emit(1'b1, w, 1'($urandom), 1'($urandom), 1'($urandom), o, cut, n);
        if (k inside {K_R, K_I, K_LW, K_SW, K_BEQ}) begin
            o = '0;
            {o.alu, o.alub} = alu_of(w);
            if (k == K_BEQ) begin
                o.pc_write = z;
                o.npc      = 3'd1;
            end
            emit(1'b1, w, (k == K_BEQ) ? z : 1'($urandom), 1'($urandom), 1'($urandom), o, cut, n);
            if (k == K_LW || k == K_SW) begin
                for (int i = 0; i <= dw; i++) begin
                    o = '0;
                    o.dmem_req  = 1'b1;
                    o.mem_write = (k == K_SW);
                    emit(1'b1, w, 1'($urandom), 1'($urandom), (i == dw), o, cut, n);
                end
            end
            if (k inside {K_R, K_I, K_LW}) begin
                o = '0;
                o.reg_write = 1'b1;
                o.ra        = (k == K_R) ? 2'd1 : 2'd0;
                o.rd        = (k == K_LW) ? 3'd1 : 3'd0;
                emit(1'b1, w, 1'($urandom), 1'($urandom), 1'($urandom), o, cut, n);
            end
        end
        if (cut < 0) model_ret++;
    endtask

    task automatic add_reset(input int cycles);
        int n;
        n = 0;
        model_ret = 0;
        for (int i = 0; i < cycles; i++) emit(1'b0, $urandom(), 1'($urandom), 1'b1, 1'b1, '0, -1, n);
        emit(1'b1, $urandom(), 1'($urandom), 1'b1, 1'b1, '0, -1, n);
    endtask

    task automatic play();
        rec_t r;
        while (q.size() > 0) begin
            r = q.pop_front();
            @(negedge clk);
            reset          = r.rst_n;
            bus.instr      = r.instr;
            bus.zero       = r.zero;
            bus.imem_ready = r.irdy;
            bus.dmem_ready = r.drdy;
            #1;
            check("outputs", 64'(dut_out()), 64'(r.exp));
            check("retired", 64'(retired), 64'(r.exp_ret));
        end
    endtask

    task automatic add_len(input string name, input logic [31:0] w, input logic z,
                           input int dw, input int len);
        int sz;
        sz = q.size();
        add_instr(w, z, 0, dw, -1);
        check(name, 64'(q.size() - sz), 64'(len));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 12))
            0:  return {6'h00, r[25:6], 6'h21};
            1:  return {6'h00, r[25:6], 6'h23};
            2:  return {6'h00, r[25:6], 6'h08};
            3:  return {6'h0D, r[25:0]};
            4:  return {6'h0F, r[25:0]};
            5:  return {6'h23, r[25:0]};
            6:  return {6'h2B, r[25:0]};
            7:  return {6'h04, r[25:0]};
            8:  return {6'h02, r[25:0]};
            9:  return {6'h03, r[25:0]};
            10: return 32'd0;
            11: return {6'h00, r[25:6], 6'h20};
            default: return r;
        endcase
    endfunction

    initial begin
        bus.instr      = '0;
        bus.zero       = 1'b0;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b0;

        // Directed program with hand-counted cycle lengths pinning the trace model.
        add_reset(3);
        add_len("len_addu",    32'h00221821, 1'b0, 0, 4);
        add_len("len_lw_wait", 32'h8C220004, 1'b0, 3, 8);
        add_len("len_beq_t",   32'h10220003, 1'b1, 0, 3);
        add_len("len_beq_nt",  32'h10220003, 1'b0, 0, 3);
        add_len("len_jal",     32'h0C000010, 1'b0, 0, 2);
        add_len("len_illegal", 32'hFC000000, 1'b0, 0, 2);
        add_len("len_j",       32'h08000040, 1'b0, 0, 2);
        add_len("len_jr",      32'h03E00008, 1'b0, 0, 2);
        add_len("len_nop",     32'h00000000, 1'b0, 0, 2);
        add_len("len_ori",     32'h34220005, 1'b0, 0, 4);
        add_len("len_lui",     32'h3C011234, 1'b0, 0, 4);
        add_len("len_sw",      32'hAC220008, 1'b0, 0, 4);
        add_len("len_subu",    32'h00221823, 1'b0, 0, 4);
        play();

        // Last instruction retires at the next edge; hold FETCH so nothing else completes.
        @(negedge clk);
        bus.imem_ready = 1'b0;
        #1;
        check("retired_directed", 64'(retired), 64'd13);
        check("fetch_hold", 64'(bus.imem_req), 64'd1);

        for (int i = 0; i < 250; i++) begin
            add_instr(rand_instr(), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), -1);
        end
        play();

        // Reset in the middle of a load's MEM phase, then resume.
        @(negedge clk);
        bus.imem_ready = 1'b0;
        add_instr(32'h8C220004, 1'b0, 0, 5, 5);
        add_reset(2);
        for (int i = 0; i < 60; i++) begin
            add_instr(rand_instr(), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), -1);
        end
        play();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
